// File: rtl/node_drv_pkg.sv
// Shared types and constants for the node_driver sweep engine and its response MISR.
package node_drv_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int          VEC_W_DEF = 10;
  localparam int          SIG_W_DEF = 16;
  localparam int          PACK_W    = 10;
  // x^16 + x^12 + x^5 + 1 with the x^16 term implicit
  localparam logic [15:0] MISR_POLY = 16'h1021;

endpackage

// File: rtl/node_drv_misr.sv
// Galois LFSR-MISR that folds one response bit per sample into a running signature.
module node_drv_misr
  import node_drv_pkg::*;
#(
  parameter int               SIG_W = SIG_W_DEF,
  parameter logic [SIG_W-1:0] POLY  = SIG_W'(MISR_POLY)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear_i,
  input  logic             shift_en_i,
  input  logic             din_i,
  output logic [SIG_W-1:0] sig_o
);

  logic [SIG_W-1:0] sig_q, sig_d;

  always_comb begin
    sig_d = sig_q;
    if (clear_i) begin
      sig_d = '0;
    end else if (shift_en_i) begin
      sig_d = {sig_q[SIG_W-2:0], 1'b0} ^ ((sig_q[SIG_W-1] ^ din_i) ? POLY : '0);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sig_q <= '0;
    else     sig_q <= sig_d;
  end

  assign sig_o = sig_q;

endmodule

// File: rtl/node_driver.sv
// On-FPGA self-test: sweeps every packed input vector into a node and accumulates its response.
// Optional feature macro NODE_DRIVER_MISR_EN selects an LFSR-MISR signature instead of the ones count.
module node_driver
  import node_drv_pkg::*;
#(
  parameter int VEC_W      = VEC_W_DEF,
  parameter int HOLD_CYC   = 4,
  parameter int SAMPLE_OFS = 3,
  parameter int SIG_W      = SIG_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic [1:0]       node_in,
  output logic [1:0]       node_in1,
  output logic [1:0]       node_in2,
  output logic [1:0]       node_in3,
  output logic [1:0]       node_in4,
  output logic             node_high,
  input  logic             node_out,
  output logic             busy,
  output logic             done,
  output logic [VEC_W-1:0] vec_idx,
  output logic [VEC_W:0]   ones_cnt,
  output logic [SIG_W-1:0] signature
);

  localparam int               HC_W    = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;
  localparam logic [VEC_W-1:0] VEC_MAX = {VEC_W{1'b1}};
  localparam logic [HC_W-1:0]  HC_LAST = HC_W'(HOLD_CYC - 1);
  localparam logic [HC_W-1:0]  HC_SMP  = HC_W'(SAMPLE_OFS);

  state_e            state_q, state_d;
  logic [VEC_W-1:0]  vec_q, vec_d;
  logic [HC_W-1:0]   hold_q, hold_d;
  logic [VEC_W:0]    ones_q, ones_d;
  logic [PACK_W-1:0] node_vec_q;
  logic              smp_vld_q, smp_last_q;
  logic [HC_W-1:0]   smp_hold_q;
  logic              start_acc, smp_tick, fin;
  logic [SIG_W-1:0]  sig_w;

  // node_in lags vec_q by one cycle, so sampling and end-of-sweep use the delayed counter
  assign start_acc = (state_q == IDLE) && start;
  assign smp_tick  = (state_q == HOLD) && smp_vld_q && (smp_hold_q == HC_SMP);
  assign fin       = (state_q == HOLD) && smp_vld_q && smp_last_q && (smp_hold_q == HC_LAST);

  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    hold_d  = hold_q;
    ones_d  = ones_q;
    unique case (state_q)
      IDLE: begin
        if (start_acc) begin
          state_d = HOLD;
          vec_d   = '0;
          hold_d  = '0;
          ones_d  = '0;
        end
      end
      HOLD: begin
        if (hold_q == HC_LAST) begin
          hold_d = '0;
          if (vec_q != VEC_MAX) vec_d = vec_q + VEC_W'(1);
        end else begin
          hold_d = hold_q + HC_W'(1);
        end
        if (smp_tick) ones_d = ones_q + {{VEC_W{1'b0}}, node_out};
        if (fin)      state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
        vec_d   = '0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      vec_q      <= '0;
      hold_q     <= '0;
      ones_q     <= '0;
      node_vec_q <= '0;
      smp_vld_q  <= 1'b0;
      smp_last_q <= 1'b0;
      smp_hold_q <= '0;
    end else begin
      state_q    <= state_d;
      vec_q      <= vec_d;
      hold_q     <= hold_d;
      ones_q     <= ones_d;
      node_vec_q <= PACK_W'(vec_q);
      smp_vld_q  <= (state_q == HOLD);
      smp_last_q <= (vec_q == VEC_MAX);
      smp_hold_q <= hold_q;
    end
  end

`ifdef NODE_DRIVER_MISR_EN
  node_drv_misr #(.SIG_W(SIG_W)) u_misr (
    .clk       (clk),
    .rst       (rst),
    .clear_i   (start_acc),
    .shift_en_i(smp_tick),
    .din_i     (node_out),
    .sig_o     (sig_w)
  );
`else
  assign sig_w = SIG_W'(ones_q);
`endif

  assign node_in   = node_vec_q[9:8];
  assign node_in1  = node_vec_q[7:6];
  assign node_in2  = node_vec_q[5:4];
  assign node_in3  = node_vec_q[3:2];
  assign node_in4  = node_vec_q[1:0];
  assign busy      = (state_q == HOLD);
  assign node_high = (state_q == HOLD);
  assign done      = (state_q == DONE);
  assign vec_idx   = vec_q;
  assign ones_cnt  = ones_q;
  assign signature = sig_w;

endmodule

// File: tb/tb_node_driver.sv
// Self-checking bench for node_driver: table-driven sweeps plus abort/restart and offset sequences.
module tb_node_driver;

  localparam int NVEC = 1024;

  logic        clk = 1'b0;
  logic        rst, start, node_out;
  logic [1:0]  node_in, node_in1, node_in2, node_in3, node_in4;
  logic        node_high, busy, done;
  logic [9:0]  vec_idx;
  logic [10:0] ones_cnt;
  logic [15:0] signature;

  logic        start2, node_out2;
  logic [1:0]  n2_in, n2_in1, n2_in2, n2_in3, n2_in4;
  logic        node_high2, busy2, done2;
  logic [9:0]  vec_idx2;
  logic [10:0] ones_cnt2;
  logic [15:0] signature2;

  int passed = 0;
  int total  = 0;
  int mode   = 0;
  logic [NVEC-1:0] resp_tbl;
  logic [9:0]      cur_vec;

  always #5 clk = ~clk;

  node_driver dut (
    .clk(clk), .rst(rst), .start(start),
    .node_in(node_in), .node_in1(node_in1), .node_in2(node_in2),
    .node_in3(node_in3), .node_in4(node_in4), .node_high(node_high),
    .node_out(node_out), .busy(busy), .done(done), .vec_idx(vec_idx),
    .ones_cnt(ones_cnt), .signature(signature)
  );

  node_driver #(.HOLD_CYC(2), .SAMPLE_OFS(1)) dut2 (
    .clk(clk), .rst(rst), .start(start2),
    .node_in(n2_in), .node_in1(n2_in1), .node_in2(n2_in2),
    .node_in3(n2_in3), .node_in4(n2_in4), .node_high(node_high2),
    .node_out(node_out2), .busy(busy2), .done(done2), .vec_idx(vec_idx2),
    .ones_cnt(ones_cnt2), .signature(signature2)
  );

  // The bench plays the node: its response is a function of the vector it sees.
  assign cur_vec = {node_in, node_in1, node_in2, node_in3, node_in4};
  always_comb begin
    case (mode)
      0:       node_out = 1'b0;
      1:       node_out = 1'b1;
      2:       node_out = cur_vec[0];
      default: node_out = resp_tbl[cur_vec];
    endcase
  end

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  function automatic logic [NVEC-1:0] bits_for(input int m);
    logic [NVEC-1:0] b;
    for (int v = 0; v < NVEC; v++) begin
      case (m)
        0:       b[v] = 1'b0;
        1:       b[v] = 1'b1;
        2:       b[v] = v[0];
        default: b[v] = resp_tbl[v];
      endcase
    end
    return b;
  endfunction

  // Signature as polynomial division: S <- (S*x + d*x^16) mod P, bits in sweep order.
  function automatic logic [15:0] sig_model(input logic [NVEC-1:0] b);
    logic [15:0] s;
    logic [16:0] t;
    s = '0;
`ifdef NODE_DRIVER_MISR_EN
    for (int v = 0; v < NVEC; v++) begin
      t = {s, 1'b0} ^ {b[v], 16'h0000};
      if (t[16]) t = t ^ 17'h11021;
      s = t[15:0];
    end
`else
    s = 16'($countones(b));
`endif
    return s;
  endfunction

  task automatic run_sweep(input int pulse_at, output int lat, output int badrun);
    int run;
    logic [1:0] last4;
    bit pulsed;
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    check("busy_after_start", busy, 1);
    check("cleared_on_start", ones_cnt + vec_idx, 0);
    lat = 0; run = 1; last4 = node_in4; badrun = 0; pulsed = 0;
    while (lat < 10000) begin
      if (pulse_at >= 0 && !pulsed && vec_idx == 10'(pulse_at)) begin
        start = 1'b1;
        pulsed = 1;
        @(posedge clk); #1 start = 1'b0; lat++;
        check("vec_continues", (vec_idx >= 10'(pulse_at)) ? 1 : 0, 1);
        check("busy_after_restart", busy, 1);
      end else begin
        @(posedge clk); #1 lat++;
      end
      if (node_in4 != last4) begin
        if (run != 4 && lat > 6) badrun++;
        run = 1; last4 = node_in4;
      end else run++;
      if (done) break;
    end
  endtask

  typedef struct {
    int          mode;
    int          exp_ones;
    logic [15:0] exp_sig;
    int          exp_lat;
  } vec_t;

  vec_t tbl[4];

  initial begin
    int lat, badrun, ndone, c;
    logic [NVEC-1:0] b;
    rst = 1'b1; start = 1'b0; start2 = 1'b0; node_out2 = 1'b0;
    for (int v = 0; v < NVEC; v++) resp_tbl[v] = 1'($urandom_range(0, 1));
    for (int i = 0; i < 4; i++) begin
      b = bits_for(i);
      tbl[i].mode     = i;
      tbl[i].exp_ones = $countones(b);
      tbl[i].exp_sig  = sig_model(b);
      tbl[i].exp_lat  = NVEC * 4 + 1;
    end

    repeat (3) @(posedge clk);
    #1;
    check("rst_outputs", {busy, done, node_high, vec_idx, ones_cnt, signature, cur_vec}, 0);
    @(negedge clk) rst = 1'b0;
    repeat (2) @(posedge clk);
    #1 check("idle_outputs", {busy, done, node_high, vec_idx, ones_cnt, signature}, 0);

    for (int i = 0; i < 4; i++) begin
      mode = tbl[i].mode;
      run_sweep(-1, lat, badrun);
      check($sformatf("lat_m%0d", i), lat, tbl[i].exp_lat);
      check($sformatf("ones_m%0d", i), ones_cnt, tbl[i].exp_ones);
      check($sformatf("sig_m%0d", i), signature, tbl[i].exp_sig);
      check($sformatf("busy_low_at_done_m%0d", i), busy, 0);
      check($sformatf("vec_final_m%0d", i), vec_idx, NVEC - 1);
      check($sformatf("hold_runs_m%0d", i), badrun, 0);
      @(posedge clk); #1;
      check($sformatf("done_pulse_m%0d", i), done, 0);
      check($sformatf("vec_return_m%0d", i), vec_idx, 0);
      repeat (4) @(posedge clk);
      #1 check($sformatf("ones_held_m%0d", i), ones_cnt, tbl[i].exp_ones);
    end

    // Start mid-sweep is ignored; start during DONE is ignored too.
    mode = 1;
    run_sweep(100, lat, badrun);
    check("lat_restart", lat, NVEC * 4 + 1);
    check("ones_restart", ones_cnt, NVEC);
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    check("start_in_done_ignored", busy, 0);
    ndone = 0;
    repeat (20) begin @(posedge clk); #1 if (done) ndone++; end
    check("single_done", ndone + (busy ? 100 : 0), 0);

    // Asynchronous abort near vector 500, then a clean sweep.
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    c = 0;
    while (vec_idx != 10'd500 && c < 5000) begin @(posedge clk); #1 c++; end
    check("reach_500", vec_idx, 500);
    check("ones_before_abort", (ones_cnt > 0) ? 1 : 0, 1);
    @(negedge clk); rst = 1'b1;
    #1 check("abort_outputs", {busy, done, node_high, vec_idx, ones_cnt, signature, cur_vec}, 0);
    @(negedge clk); rst = 1'b0;
    run_sweep(-1, lat, badrun);
    check("lat_after_abort", lat, NVEC * 4 + 1);
    check("ones_after_abort", ones_cnt, NVEC);
    check("sig_after_abort", signature, tbl[1].exp_sig);

    // Short hold: the node answers 1 only in the sample cycle of each vector.
    @(negedge clk); start2 = 1'b1;
    @(posedge clk); #1 start2 = 1'b0; node_out2 = 1'b0;
    c = 0;
    while (c < 6000) begin
      @(posedge clk); #1 c++;
      if (done2) break;
      node_out2 = (((c - 1) % 2) == 1);
    end
    node_out2 = 1'b0;
    check("lat_hold2", c, NVEC * 2 + 1);
    check("ones_hold2", ones_cnt2, NVEC);
    check("sig_hold2", signature2, tbl[1].exp_sig);
    check("busy2_low", busy2, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
